load_store_unit: RTL and testbench

MEM-stage initiator for the 32-bit pipeline's word-addressed data memory. It accepts one load/store request at a time from the pipeline and checks alignment and range. It drives the memory's read/write strobes and performs read-modify-write for byte and halfword stores. It returns sign- or zero-extended load data, or an error flag, through a valid/ready response handshake.

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_align.sv | 70 +++++++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the MEM-stage load/store unit: bus widths, request
// op codes ({we, funct3}), the controller state enum, and small helpers
// that classify an op code.
package lsu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_LB  = 4'b0000;
  localparam logic [OP_W-1:0] OP_LH  = 4'b0001;
  localparam logic [OP_W-1:0] OP_LW  = 4'b0010;
  localparam logic [OP_W-1:0] OP_LBU = 4'b0100;
  localparam logic [OP_W-1:0] OP_LHU = 4'b0101;
  localparam logic [OP_W-1:0] OP_SB  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SH  = 4'b1001;
  localparam logic [OP_W-1:0] OP_SW  = 4'b1010;

  // Access size lives in the low two bits of every legal op code.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: legal = 1'b1;
      default:             legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic op_misaligned(input logic [1:0] size,
                                         input logic [1:0] byte_off);
    logic mis;
    case (size)
      SIZE_HALF: mis = byte_off[0];
      SIZE_WORD: mis = (byte_off != 2'b00);
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Purely combinational lane logic for the load/store unit.
//   i_op         : latched request op code
//   i_byte_off   : byte offset within the word (addr[1:0])
//   i_rdata      : word sampled from data memory
//   i_wdata_lo   : low halfword of the store data (SB uses [7:0])
//   o_load_data  : selected lane, sign- or zero-extended per op
//   o_merge_data : i_rdata with the SB/SH store lane replaced
// Lanes are little-endian: byte offset 0 is bits [7:0].
module lsu_align
  import lsu_pkg::*;
(
  input  logic [OP_W-1:0]   i_op,
  input  logic [1:0]        i_byte_off,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [15:0]       i_wdata_lo,
  output logic [DATA_W-1:0] o_load_data,
  output logic [DATA_W-1:0] o_merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_byte_off)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase

    // Halfword accesses are already known aligned, so only bit 1 picks the lane.
    w_half = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_load_data = '0;
    case (i_op)
      OP_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU: o_load_data = {24'h000000, w_byte};
      OP_LH:  o_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU: o_load_data = {16'h0000, w_half};
      OP_LW:  o_load_data = i_rdata;
      default: o_load_data = '0;
    endcase
  end

  always_comb begin
    o_merge_data = i_rdata;
    case (i_op)
      OP_SB: begin
        case (i_byte_off)
          2'd0: o_merge_data[7:0]   = i_wdata_lo[7:0];
          2'd1: o_merge_data[15:8]  = i_wdata_lo[7:0];
          2'd2: o_merge_data[23:16] = i_wdata_lo[7:0];
          2'd3: o_merge_data[31:24] = i_wdata_lo[7:0];
          default: o_merge_data = i_rdata;
        endcase
      end
      OP_SH: begin
        if (i_byte_off[1]) o_merge_data[31:16] = i_wdata_lo;
        else               o_merge_data[15:0]  = i_wdata_lo;
      end
      default: o_merge_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// MEM-stage initiator for the word-addressed data memory. Takes one request
// at a time, rejects illegal/misaligned/out-of-range accesses without
// touching memory, does read-modify-write for SB/SH, and returns the result
// through a valid/ready response handshake.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata request fields, latched on accept
//   resp_valid/resp_ready     response handshake
//   resp_data/resp_err        extended load data / error flag
//   mem_readEn/mem_writeEn    memory strobes (mutually exclusive)
//   mem_address               latched word index addr[31:2]
//   mem_WriteData             word to write
//   mem_ReadData              combinational read data
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; req_ready high
// READ    | mem_readEn high; loads extract a lane, SB/SH build a merge
// WRITE   | mem_writeEn high for one cycle (SW data or merged word)
// RESP    | resp_valid high until resp_ready
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_readEn,
  output logic              mem_writeEn,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_WriteData,
  input  logic [DATA_W-1:0] mem_ReadData
);

  localparam logic [ADDR_W-1:0] LP_MEM_WORDS = ADDR_W'(MEM_WORDS);

  lsu_state_t        r_state;
  lsu_state_t        w_state_nxt;

  logic [OP_W-1:0]   r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_merge;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_err;

  logic              w_accept;
  logic              w_req_err;
  logic              w_sub_word_store;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merge_data;

  assign w_accept = req_valid && (r_state == ST_IDLE);

  // Anything rejected here never reaches READ/WRITE, so no strobe is issued.
  assign w_req_err = !op_legal(req_op)
                  || op_misaligned(req_op[1:0], req_addr[1:0])
                  || ({2'b00, req_addr[ADDR_W-1:2]} >= LP_MEM_WORDS);

  // SB/SH need the old word first; SW goes straight to WRITE.
  assign w_sub_word_store = r_op[3] && (r_op[1:0] != SIZE_WORD);

  lsu_align u_align (
    .i_op         (r_op),
    .i_byte_off   (r_addr[1:0]),
    .i_rdata      (mem_ReadData),
    .i_wdata_lo   (r_wdata[15:0]),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_readEn    = 1'b0;
    mem_writeEn   = 1'b0;
    mem_WriteData = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_req_err)            w_state_nxt = ST_RESP;
          else if (req_op == OP_SW) w_state_nxt = ST_WRITE;
          else                      w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        mem_readEn  = 1'b1;
        w_state_nxt = r_op[3] ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        mem_writeEn   = 1'b1;
        mem_WriteData = w_sub_word_store ? r_merge : r_wdata;
        w_state_nxt   = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_op        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_merge     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op        <= req_op;
        r_addr      <= req_addr;
        r_wdata     <= req_wdata;
        r_resp_data <= '0;
        r_resp_err  <= w_req_err;
      end
      if (r_state == ST_READ) begin
        if (r_op[3]) r_merge     <= w_merge_data;
        else         r_resp_data <= w_load_data;
      end
      if ((r_state == ST_RESP) && resp_ready) begin
        r_resp_data <= '0;
        r_resp_err  <= 1'b0;
      end
    end
  end

  assign resp_data   = r_resp_data;
  assign resp_err    = r_resp_err;
  assign mem_address = {2'b00, r_addr[ADDR_W-1:2]};

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_readEn;
  logic        mem_writeEn;
  logic [31:0] mem_address;
  logic [31:0] mem_WriteData;
  logic [31:0] mem_ReadData;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(WORDS)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .mem_readEn    (mem_readEn),
    .mem_writeEn   (mem_writeEn),
    .mem_address   (mem_address),
    .mem_WriteData (mem_WriteData),
    .mem_ReadData  (mem_ReadData)
  );

  // Data memory seen by the DUT, and the reference image kept by the model.
  logic [31:0] mem     [0:WORDS-1];
  logic [31:0] ref_mem [0:WORDS-1];

  assign mem_ReadData = (mem_address < 32'(WORDS)) ? mem[mem_address[9:0]] : 32'h0;

  always @(negedge clk) begin
    if (mem_writeEn && (mem_address < 32'(WORDS))) mem[mem_address[9:0]] = mem_WriteData;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
                      4'b1000, 4'b1001, 4'b1010};
  endfunction

  function automatic bit m_err(input logic [3:0] op, input logic [31:0] addr);
    int bytes;
    if (!m_legal(op)) return 1'b1;
    bytes = 1 << op[1:0];
    if ((addr % bytes) != 0) return 1'b1;
    return (addr / 4) >= WORDS;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] word,
                                         input int off);
    logic [31:0] w, b, h;
    w = word >> (off * 8);
    b = w % 256;
    h = w % 65536;
    case (op)
      4'b0000: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      4'b0001: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      4'b0010: return word;
      4'b0100: return b;
      4'b0101: return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [3:0] op, input logic [31:0] old,
                                          input logic [31:0] wdata, input int off);
    logic [31:0] mask;
    if (op == 4'b1010) return wdata;
    mask = ((op == 4'b1000) ? 32'hFF : 32'hFFFF) << (off * 8);
    return (old & ~mask) | ((wdata << (off * 8)) & mask);
  endfunction

  // Apply a transaction to the reference memory and produce its expectations.
  task automatic model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] ed, output logic ee, output int el,
                       output int erd, output int ewr);
    int idx;
    int off;
    idx = int'(addr / 4);
    off = int'(addr % 4);
    ee = m_err(op, addr);
    ed = 32'h0; el = 1; erd = 0; ewr = 0;
    if (!ee) begin
      if (!op[3]) begin
        ed = m_load(op, ref_mem[idx], off); el = 2; erd = 1;
      end else if (op == 4'b1010) begin
        ref_mem[idx] = wdata; el = 2; ewr = 1;
      end else begin
        ref_mem[idx] = m_store(op, ref_mem[idx], wdata, off); el = 3; erd = 1; ewr = 1;
      end
    end
  endtask

  // ---------------- driver / checker ----------------
  task automatic run_req(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold,
                         input logic [31:0] ed, input logic ee, input int el,
                         input int erd, input int ewr);
    int lat, nrd, nwr;
    bit seen;
    logic [31:0] idx;
    idx = addr >> 2;
    @(negedge clk);
    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    // Junk on the request port while busy must be ignored.
    req_op = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0; nrd = 0; nwr = 0; seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      lat++;
      if (mem_readEn)  nrd++;
      if (mem_writeEn) nwr++;
      if (mem_readEn || mem_writeEn)
        chk({tag, " strobe exclusive"}, 32'(mem_readEn && mem_writeEn), 32'd0);
      chk({tag, " mem_address"}, mem_address, idx);
      if (resp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      $display("FAIL %s response timeout: got none expected resp_valid", tag);
      bad++; total++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "response timeout");
    end
    chk({tag, " latency"}, 32'(lat), 32'(el));
    chk({tag, " resp_data"}, resp_data, ed);
    chk({tag, " resp_err"}, 32'(resp_err), 32'(ee));
    chk({tag, " reads"}, 32'(nrd), 32'(erd));
    chk({tag, " writes"}, 32'(nwr), 32'(ewr));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(resp_valid), 32'd1);
      chk({tag, " hold data"}, resp_data, ed);
      chk({tag, " hold err"}, 32'(resp_err), 32'(ee));
      chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, " hold strobes"}, 32'(mem_readEn || mem_writeEn), 32'd0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({tag, " resp drop"}, 32'(resp_valid), 32'd0);
    chk({tag, " back idle"}, 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rst resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " rst resp_data"}, resp_data, 32'd0);
    chk({tag, " rst resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, " rst readEn"}, 32'(mem_readEn), 32'd0);
    chk({tag, " rst writeEn"}, 32'(mem_writeEn), 32'd0);
    chk({tag, " rst address"}, mem_address, 32'd0);
    chk({tag, " rst wdata"}, mem_WriteData, 32'd0);
    chk({tag, " rst req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    bit          chk_mem;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vt [14];

  initial begin
    logic [31:0] ed;
    logic        ee;
    int          el, erd, ewr;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          sel;
    int          nwr;

    vt[0]  = '{4'b1010, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 0, 1, 1'b1, 32'hDEADBEEF};
    vt[1]  = '{4'b0010, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vt[2]  = '{4'b0000, 32'h08, 32'h0,        32'h00000001, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vt[3]  = '{4'b0000, 32'h09, 32'h0,        32'h0000007F, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vt[4]  = '{4'b0000, 32'h0A, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vt[5]  = '{4'b0100, 32'h0B, 32'h0,        32'h00000080, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vt[6]  = '{4'b0001, 32'h0A, 32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vt[7]  = '{4'b0101, 32'h0A, 32'h0,        32'h000080FF, 1'b0, 2, 1, 0, 1'b0, 32'h0};
    vt[8]  = '{4'b1000, 32'h21, 32'h123456AA, 32'h0,        1'b0, 3, 1, 1, 1'b1, 32'h1122AA44};
    vt[9]  = '{4'b1001, 32'h22, 32'h5555BEEF, 32'h0,        1'b0, 3, 1, 1, 1'b1, 32'hBEEFAA44};
    vt[10] = '{4'b0010, 32'h06, 32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0};
    vt[11] = '{4'b0001, 32'h03, 32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0};
    vt[12] = '{4'b0010, 32'h1000, 32'h0,      32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0};
    vt[13] = '{4'b0111, 32'h00, 32'h0,        32'h0,        1'b1, 1, 0, 0, 1'b0, 32'h0};

    for (int i = 0; i < WORDS; i++) preload(i, $urandom);
    preload(2, 32'h80FF7F01);
    preload(8, 32'h11223344);

    rst = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("init");
    rst = 1'b1;

    // Directed vectors; the model runs alongside so ref_mem tracks the stores.
    for (int i = 0; i < 14; i++) begin
      model(vt[i].op, vt[i].addr, vt[i].wdata, ed, ee, el, erd, ewr);
      run_req($sformatf("vec%0d", i), vt[i].op, vt[i].addr, vt[i].wdata, 0,
              vt[i].exp_data, vt[i].exp_err, vt[i].exp_lat, vt[i].exp_rd, vt[i].exp_wr);
      if (vt[i].chk_mem) chk($sformatf("vec%0d mem", i), mem[vt[i].addr >> 2], vt[i].exp_mem);
    end

    // Response back-pressure: five cycles of resp_ready low after an LW.
    model(4'b0010, 32'h10, 32'h0, ed, ee, el, erd, ewr);
    run_req("hold5", 4'b0010, 32'h10, 32'h0, 5, 32'hDEADBEEF, 1'b0, 2, 1, 0);

    // Reset at the posedge that ends the READ of an SB.
    preload(5, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'b1000; req_addr = 32'h15; req_wdata = 32'h99;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid in READ", 32'(mem_readEn), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    nwr = 0;
    if (mem_writeEn) nwr++;
    chk_reset_outputs("rstmid");
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_writeEn) nwr++;
      chk("rstmid idle ready", 32'(req_ready), 32'd1);
      chk("rstmid no resp", 32'(resp_valid), 32'd0);
    end
    chk("rstmid writes", 32'(nwr), 32'd0);
    chk("rstmid word", mem[5], 32'h55667788);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: op = 4'b0000;
        1: op = 4'b0001;
        2: op = 4'b0010;
        3: op = 4'b0100;
        4: op = 4'b0101;
        5: op = 4'b1000;
        6: op = 4'b1001;
        7: op = 4'b1010;
        default: begin
          op = 4'($urandom);
          while (m_legal(op)) op = 4'($urandom);
        end
      endcase
      if ($urandom_range(0, 9) == 0) addr = $urandom | 32'h00001000;
      else addr = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      wdata = $urandom;
      model(op, addr, wdata, ed, ee, el, erd, ewr);
      run_req($sformatf("rnd%0d op%h a%h", n, op, addr), op, addr, wdata,
              $urandom_range(0, 2), ed, ee, el, erd, ewr);
      if (ewr != 0) chk($sformatf("rnd%0d mem", n), mem[addr >> 2], ref_mem[addr >> 2]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
